ann_layer_engine: RTL and testbench
===================================

# ann_layer_engine

Parametrised fully-connected neural-network layer for the drowsiness detector: N_OUT neurons, each with N_IN signed fixed-point weights, evaluated by N_OUT parallel multiply-accumulate lanes over N_IN cycles. It has an optional hard-sigmoid activation and an in-place delta-rule weight-update mode for on-chip training. One instance serves as the hidden layer (30→5) and one as the output layer (5→3). A top-level controller sequences the two.

## Interface
- N_IN, 30, inputs per neuron (≥2)
- N_OUT, 5, neurons / parallel MAC lanes (≥1)
- W, 10, data/weight width, signed two's complement
- FRAC, 6, fraction bits (Q format, 1.0 = 2^FRAC); FRAC ≤ W-2
- AW, $clog2(N_IN*N_OUT), weight address width
- Clock  in  1  single clock; all logic on rising edge
- Rst  in  1  asynchronous, active-low reset
- start  in  1  begin inference (pulse; sampled in IDLE only)
- upd_start  in  1  begin weight update (pulse; IDLE only)
- act_en  in  1  1 = hard-sigmoid output, 0 = linear (saturated sum); sampled with start
- lr_shift  in  4  learning-rate right shift; sampled with upd_start
- x_in  in  N_IN*W  input vector, element i at [i*W +: W]; latched on start
- err_in  in  N_OUT*W  per-neuron error (target − output), lane j at [j*W +: W]; latched on upd_start
- w_we  in  1  weight write strobe (IDLE only)
- w_addr  in  AW  weight index j*N_IN+i
- w_wdata  in  W  write data
- w_rdata  out  W  combinational readback of weight[w_addr]; 0 if out of range
- y_out  out  N_OUT*W  registered layer outputs
- busy  out  1  high in MAC/UPD states
- done  out  1  one-cycle pulse, y_out valid
- upd_done  out  1  one-cycle pulse, update complete
- sat_flag  out  1  any lane saturated in last inference

## Operation
- States: IDLE, MAC, UPD. Column counter k: 0..N_IN-1.
- IDLE + start: latch x_in→x_reg and act_en, clear N_OUT accumulators and k, go to MAC. start takes priority over upd_start in the same cycle.
- MAC: per cycle acc[j] += w[j][k] * x_reg[k] (2W-bit signed product; accumulator 2W+$clog2(N_IN) bits, no overflow). After k = N_IN-1, go to IDLE, register the outputs, and pulse done.
- Output: s = acc >>> FRAC (arithmetic), saturated to [-2^(W-1), 2^(W-1)-1]. If act_en: y = 2^(FRAC-1) + (s >>> 2), clamped to [0, 2^FRAC]. sat_flag = OR over lanes of linear-saturation events. It is updated only at done and held otherwise.
- IDLE + upd_start: latch err_in and lr_shift, go to UPD. Uses the x_reg from the last inference.
- UPD: per cycle, for every j: w[j][k] += (err[j]*x_reg[k]) >>> (FRAC+lr_shift), with the sum saturated to W bits. After k = N_IN-1, go to IDLE and pulse upd_done.
- w_we in IDLE writes weight[w_addr] ← w_wdata. Out-of-range addresses are ignored.
- Ignored inputs: w_we, start, and upd_start are ignored while busy.
- Reset (any time, including mid-MAC/UPD): state→IDLE. All weights, x_reg, err, accumulators, y_out, done, upd_done, busy, and sat_flag → 0. An interrupted operation is lost and produces no done or upd_done pulse.

## Timing
- Start edge = edge 0. Edges 1..N_IN perform the MAC for k=0..N_IN-1. At edge N_IN+1: y_out and sat_flag update, done=1 for one cycle, busy=0.
- busy goes high at edge 0+ (visible the cycle after start) and stays high N_IN+1 cycles.
- UPD uses identical timing: weight column k is written at edge k+1, and upd_done is pulsed at edge N_IN+1.
- A new start is accepted in the cycle done is high; back-to-back throughput is one inference per N_IN+2 cycles.
- w_rdata reflects a write on the following cycle.
- y_out holds between inferences; UPD does not change y_out.

## Test plan
Bench configuration: N_IN=4, N_OUT=2, W=10, FRAC=6 (1.0 = 64).

- Linear inference: all weights 64, x=32 each, act_en=0 → y_out = {128,128}, sat_flag=0; done exactly 5 cycles after start, busy high 5 cycles.
- Activation: same data with act_en=1 → 32+(128>>>2)=64 → {64,64}. With weights −64 → 32−32=0 → {0,0} (lower clamp).
- Saturation: weights 511, x 511 → {511,511}, sat_flag=1. Lane 1 weights −512 → −512 for that lane. A subsequent in-range inference clears sat_flag.
- Training: weights 0, inference with x=64, then err={64,−64}, lr_shift=0 → weights become lane0 64 and lane1 −64 (check via w_rdata). Repeat with lr_shift=2 → ±16 increments. upd_done comes 5 cycles after upd_start.
- Protocol: start, upd_start, and w_we asserted mid-MAC are ignored (no extra done, weights unchanged). Simultaneous start+upd_start in IDLE → inference only.
- Reset mid-MAC (edge 2) → busy=0, y_out=0, all weights read 0, and no done pulse for the aborted inference; the next start works normally.

Source files
------------

// File: rtl/ann_layer_engine_if.sv
// Bundle of control, data and weight-port signals for one ann_layer_engine instance.
// The master side (controller or bench) drives requests; the slave side is the layer.
interface ann_layer_engine_if #(
  parameter int N_IN  = 30,
  parameter int N_OUT = 5,
  parameter int W     = 10,
  parameter int AW    = $clog2(N_IN * N_OUT)
);
  logic               start;
  logic               upd_start;
  logic               act_en;
  logic [3:0]         lr_shift;
  logic [N_IN*W-1:0]  x_in;
  logic [N_OUT*W-1:0] err_in;
  logic               w_we;
  logic [AW-1:0]      w_addr;
  logic [W-1:0]       w_wdata;
  logic [W-1:0]       w_rdata;
  logic [N_OUT*W-1:0] y_out;
  logic               busy;
  logic               done;
  logic               upd_done;
  logic               sat_flag;

  modport master (
    output start, upd_start, act_en, lr_shift, x_in, err_in, w_we, w_addr, w_wdata,
    input  w_rdata, y_out, busy, done, upd_done, sat_flag
  );

  modport slave (
    input  start, upd_start, act_en, lr_shift, x_in, err_in, w_we, w_addr, w_wdata,
    output w_rdata, y_out, busy, done, upd_done, sat_flag
  );
endinterface

// File: rtl/ann_layer_engine.sv
// Fully-connected layer: N_OUT parallel MAC lanes stepping over N_IN columns,
// optional hard-sigmoid output, and an in-place delta-rule weight update.
module ann_layer_engine #(
  parameter int N_IN  = 30,
  parameter int N_OUT = 5,
  parameter int W     = 10,
  parameter int FRAC  = 6,
  parameter int AW    = $clog2(N_IN * N_OUT)
) (
  input  logic clk,
  input  logic rst_n,
  ann_layer_engine_if.slave bus
);
  localparam int NW    = N_IN * N_OUT;
  localparam int KW    = $clog2(N_IN + 1);
  localparam int CW    = $clog2(N_IN);
  localparam int PW    = 2 * W;
  localparam int ACC_W = 2 * W + $clog2(N_IN);

  localparam logic signed [W-1:0]     W_MAX   = W'(2 ** (W - 1) - 1);
  localparam logic signed [W-1:0]     W_MIN   = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(W_MAX);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(W_MIN);
  localparam logic signed [PW:0]      SUM_MAX = (PW+1)'(W_MAX);
  localparam logic signed [PW:0]      SUM_MIN = (PW+1)'(W_MIN);
  localparam logic signed [W:0]       HALF    = (W+1)'(2 ** (FRAC - 1));
  localparam logic signed [W:0]       ONE     = (W+1)'(2 ** FRAC);
  localparam logic [AW:0]             NW_E    = (AW+1)'(NW);

  typedef enum logic [1:0] {IDLE, MAC, UPD} state_t;

  state_t                  state;
  logic [KW-1:0]           k;
  logic [CW-1:0]           col;
  logic signed [W-1:0]     weights [NW];
  logic signed [W-1:0]     x_reg   [N_IN];
  logic signed [W-1:0]     err_reg [N_OUT];
  logic signed [ACC_W-1:0] acc     [N_OUT];
  logic                    act_reg;
  logic [3:0]              lr_reg;
  logic [N_OUT*W-1:0]      y_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic                    upd_done_reg;
  logic                    sat_reg;

  logic                    addr_ok;
  logic signed [W-1:0]     x_cur;
  logic [7:0]              shamt;
  logic [AW-1:0]           col_addr [N_OUT];
  logic signed [W-1:0]     w_col    [N_OUT];
  logic signed [PW-1:0]    mac_prod [N_OUT];
  logic signed [PW-1:0]    delta    [N_OUT];
  logic signed [PW:0]      upd_sum  [N_OUT];
  logic signed [W-1:0]     w_new    [N_OUT];
  logic signed [ACC_W-1:0] s_full   [N_OUT];
  logic signed [W-1:0]     s_sat    [N_OUT];
  logic signed [W:0]       act_val  [N_OUT];
  logic signed [W-1:0]     y_next   [N_OUT];
  logic [N_OUT-1:0]        lane_sat;

  assign col     = k[CW-1:0];
  assign addr_ok = {1'b0, bus.w_addr} < NW_E;

  assign bus.w_rdata  = addr_ok ? weights[bus.w_addr] : '0;
  assign bus.y_out    = y_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.upd_done = upd_done_reg;
  assign bus.sat_flag = sat_reg;

  // Per-lane datapath for the current column: MAC product, saturated weight update,
  // and the output stage evaluated from the finished accumulators.
  always_comb begin
    x_cur    = x_reg[col];
    shamt    = 8'(FRAC) + {4'd0, lr_reg};
    lane_sat = '0;
    for (int j = 0; j < N_OUT; j++) begin
      col_addr[j] = AW'(j * N_IN + int'(col));
      w_col[j]    = weights[col_addr[j]];
      mac_prod[j] = PW'(w_col[j]) * PW'(x_cur);
      delta[j]    = (PW'(err_reg[j]) * PW'(x_cur)) >>> shamt;
      upd_sum[j]  = (PW+1)'(w_col[j]) + (PW+1)'(delta[j]);
      if (upd_sum[j] > SUM_MAX)
        w_new[j] = W_MAX;
      else if (upd_sum[j] < SUM_MIN)
        w_new[j] = W_MIN;
      else
        w_new[j] = upd_sum[j][W-1:0];

      s_full[j] = acc[j] >>> FRAC;
      if (s_full[j] > ACC_MAX) begin
        s_sat[j]    = W_MAX;
        lane_sat[j] = 1'b1;
      end else if (s_full[j] < ACC_MIN) begin
        s_sat[j]    = W_MIN;
        lane_sat[j] = 1'b1;
      end else begin
        s_sat[j] = s_full[j][W-1:0];
      end

      act_val[j] = HALF + (W+1)'(s_sat[j] >>> 2);
      if (!act_reg)
        y_next[j] = s_sat[j];
      else if (act_val[j] < 0)
        y_next[j] = '0;
      else if (act_val[j] > ONE)
        y_next[j] = W'(ONE);
      else
        y_next[j] = act_val[j][W-1:0];
    end
  end

  // Sequencer: k runs one step past the last column so results land on edge N_IN+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      k            <= '0;
      act_reg      <= 1'b0;
      lr_reg       <= '0;
      y_reg        <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      upd_done_reg <= 1'b0;
      sat_reg      <= 1'b0;
      for (int i = 0; i < NW; i++)    weights[i] <= '0;
      for (int i = 0; i < N_IN; i++)  x_reg[i]   <= '0;
      for (int j = 0; j < N_OUT; j++) err_reg[j] <= '0;
      for (int j = 0; j < N_OUT; j++) acc[j]     <= '0;
    end else begin
      done_reg     <= 1'b0;
      upd_done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.w_we && addr_ok)
            weights[bus.w_addr] <= bus.w_wdata;
          if (bus.start) begin
            for (int i = 0; i < N_IN; i++) x_reg[i] <= bus.x_in[i*W +: W];
            for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
            act_reg  <= bus.act_en;
            k        <= '0;
            busy_reg <= 1'b1;
            state    <= MAC;
          end else if (bus.upd_start) begin
            for (int j = 0; j < N_OUT; j++) err_reg[j] <= bus.err_in[j*W +: W];
            lr_reg   <= bus.lr_shift;
            k        <= '0;
            busy_reg <= 1'b1;
            state    <= UPD;
          end
        end
        MAC: begin
          if (k == KW'(N_IN)) begin
            for (int j = 0; j < N_OUT; j++) y_reg[j*W +: W] <= y_next[j];
            sat_reg  <= |lane_sat;
            done_reg <= 1'b1;
            busy_reg <= 1'b0;
            state    <= IDLE;
          end else begin
            for (int j = 0; j < N_OUT; j++) acc[j] <= acc[j] + ACC_W'(mac_prod[j]);
            k <= k + KW'(1);
          end
        end
        UPD: begin
          if (k == KW'(N_IN)) begin
            upd_done_reg <= 1'b1;
            busy_reg     <= 1'b0;
            state        <= IDLE;
          end else begin
            for (int j = 0; j < N_OUT; j++) weights[col_addr[j]] <= w_new[j];
            k <= k + KW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ann_layer_engine.sv
// Self-checking bench for ann_layer_engine (4 inputs, 2 lanes, Q3.6) against an
// integer reference model of the layer's arithmetic.
module tb_ann_layer_engine;
  localparam int N_IN  = 4;
  localparam int N_OUT = 2;
  localparam int W     = 10;
  localparam int FRAC  = 6;
  localparam int AW    = 3;
  localparam int NW    = N_IN * N_OUT;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  // Free-running 10 ns clock; checks are sampled on the falling edge.
  always #5 clk = ~clk;

  ann_layer_engine_if #(.N_IN(N_IN), .N_OUT(N_OUT), .W(W), .AW(AW)) bus ();

  ann_layer_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .W(W), .FRAC(FRAC), .AW(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int m_w [NW];
  int m_x [N_IN];
  int m_y [N_OUT];
  int m_sat;
  int stim_x   [N_IN];
  int stim_err [N_OUT];

  task automatic checkOutput(input string tag, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int clampRange(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int yLane(input int j);
    return int'($signed(bus.y_out[j*W +: W]));
  endfunction

  // Reference layer: dot product, rescale, saturate, optional hard sigmoid.
  task automatic modelInfer(input bit act);
    int acc, s;
    m_sat = 0;
    for (int j = 0; j < N_OUT; j++) begin
      acc = 0;
      for (int i = 0; i < N_IN; i++) acc += m_w[j*N_IN + i] * m_x[i];
      s = acc >>> FRAC;
      if (s > 511 || s < -512) m_sat = 1;
      s = clampRange(s, -512, 511);
      m_y[j] = act ? clampRange(32 + (s >>> 2), 0, 64) : s;
    end
  endtask

  task automatic modelUpdate(input int lr);
    for (int j = 0; j < N_OUT; j++)
      for (int i = 0; i < N_IN; i++)
        m_w[j*N_IN + i] = clampRange(m_w[j*N_IN + i] + ((stim_err[j] * m_x[i]) >>> (FRAC + lr)), -512, 511);
  endtask

  task automatic idleInputs();
    bus.start = 1'b0; bus.upd_start = 1'b0; bus.act_en = 1'b0; bus.lr_shift = '0;
    bus.x_in = '0; bus.err_in = '0; bus.w_we = 1'b0; bus.w_addr = '0; bus.w_wdata = '0;
  endtask

  task automatic writeWeight(input int addr, input int val);
    @(negedge clk);
    bus.w_we = 1'b1; bus.w_addr = AW'(addr); bus.w_wdata = W'(val);
    @(posedge clk);
    @(negedge clk);
    bus.w_we = 1'b0;
    m_w[addr] = val;
  endtask

  task automatic fillWeights(input int lane0, input int lane1);
    for (int a = 0; a < NW; a++) writeWeight(a, (a < N_IN) ? lane0 : lane1);
  endtask

  task automatic checkWeights(input string tag);
    for (int a = 0; a < NW; a++) begin
      bus.w_addr = AW'(a);
      #1;
      checkOutput($sformatf("%s_w%0d", tag, a), int'($signed(bus.w_rdata)), m_w[a]);
    end
  endtask

  // Runs one inference; optionally pokes start/upd_start/w_we mid-MAC or raises
  // upd_start together with start, then checks latency, outputs and quiet aftermath.
  task automatic applyStimulus(input string tag, input bit act, input bit poke_mid, input bit with_upd);
    int n, busy_cnt, extra_done, upd_cnt;
    @(negedge clk);
    for (int i = 0; i < N_IN; i++) bus.x_in[i*W +: W] = W'(stim_x[i]);
    for (int j = 0; j < N_OUT; j++) bus.err_in[j*W +: W] = W'(stim_err[j]);
    bus.act_en = act; bus.start = 1'b1; bus.upd_start = with_upd;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.upd_start = 1'b0;
    for (int i = 0; i < N_IN; i++) m_x[i] = stim_x[i];
    n = 0; busy_cnt = 0; upd_cnt = 0;
    while (!bus.done && n < 20) begin
      if (bus.busy) busy_cnt++;
      if (bus.upd_done) upd_cnt++;
      if (poke_mid && n == 2) begin
        bus.start = 1'b1; bus.upd_start = 1'b1; bus.w_we = 1'b1;
        bus.w_addr = '0; bus.w_wdata = W'(341); bus.x_in = ~bus.x_in;
      end else begin
        bus.start = 1'b0; bus.upd_start = 1'b0; bus.w_we = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    modelInfer(act);
    checkOutput({tag, "_latency"}, n, 5);
    checkOutput({tag, "_busy_cycles"}, busy_cnt, 5);
    checkOutput({tag, "_busy_at_done"}, int'(bus.busy), 0);
    for (int j = 0; j < N_OUT; j++) checkOutput($sformatf("%s_y%0d", tag, j), yLane(j), m_y[j]);
    checkOutput({tag, "_sat"}, int'(bus.sat_flag), m_sat);
    extra_done = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.done) extra_done++;
      if (bus.upd_done) upd_cnt++;
    end
    checkOutput({tag, "_extra_done"}, extra_done, 0);
    checkOutput({tag, "_spurious_upd"}, upd_cnt, 0);
  endtask

  task automatic applyUpdate(input string tag, input int lr);
    int n;
    @(negedge clk);
    for (int j = 0; j < N_OUT; j++) bus.err_in[j*W +: W] = W'(stim_err[j]);
    bus.lr_shift = 4'(lr); bus.upd_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.upd_start = 1'b0;
    n = 0;
    while (!bus.upd_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    modelUpdate(lr);
    checkOutput({tag, "_upd_latency"}, n, 5);
    for (int j = 0; j < N_OUT; j++) checkOutput($sformatf("%s_yhold%0d", tag, j), yLane(j), m_y[j]);
    checkWeights(tag);
  endtask

  initial begin
    int done_cnt;
    idleInputs();
    for (int a = 0; a < NW; a++) m_w[a] = 0;
    for (int j = 0; j < N_OUT; j++) begin m_y[j] = 0; stim_err[j] = 0; end
    m_sat = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_done", int'(bus.done), 0);
    checkOutput("rst_y0", yLane(0), 0);
    checkOutput("rst_sat", int'(bus.sat_flag), 0);
    rst_n = 1'b1;
    checkWeights("rst");

    // Linear, activation and lower clamp
    fillWeights(64, 64);
    for (int i = 0; i < N_IN; i++) stim_x[i] = 32;
    applyStimulus("lin", 1'b0, 1'b0, 1'b0);
    applyStimulus("act", 1'b1, 1'b0, 1'b0);
    fillWeights(-64, -64);
    applyStimulus("act_lo", 1'b1, 1'b0, 1'b0);

    // Saturation high, low lane, then cleared
    fillWeights(511, 511);
    for (int i = 0; i < N_IN; i++) stim_x[i] = 511;
    applyStimulus("sat_hi", 1'b0, 1'b0, 1'b0);
    fillWeights(511, -512);
    applyStimulus("sat_lo", 1'b0, 1'b0, 1'b0);
    fillWeights(64, 64);
    for (int i = 0; i < N_IN; i++) stim_x[i] = 32;
    applyStimulus("sat_clr", 1'b0, 1'b0, 1'b0);

    // Training from zero weights
    fillWeights(0, 0);
    for (int i = 0; i < N_IN; i++) stim_x[i] = 64;
    applyStimulus("train_inf", 1'b0, 1'b0, 1'b0);
    stim_err[0] = 64; stim_err[1] = -64;
    applyUpdate("train_lr0", 0);
    applyUpdate("train_lr2", 2);

    // Protocol: mid-MAC requests ignored, start wins over upd_start
    applyStimulus("poke", 1'b0, 1'b1, 1'b0);
    checkWeights("poke");
    stim_err[0] = 100; stim_err[1] = -100;
    applyStimulus("both", 1'b1, 1'b0, 1'b1);
    checkWeights("both");

    // Reset mid-MAC
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int a = 0; a < NW; a++) m_w[a] = 0;
    for (int j = 0; j < N_OUT; j++) m_y[j] = 0;
    checkOutput("rstmid_busy", int'(bus.busy), 0);
    checkOutput("rstmid_y0", yLane(0), 0);
    checkOutput("rstmid_y1", yLane(1), 0);
    checkOutput("rstmid_sat", int'(bus.sat_flag), 0);
    @(negedge clk);
    rst_n = 1'b1;
    checkWeights("rstmid");
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    checkOutput("rstmid_no_done", done_cnt, 0);
    fillWeights(64, -64);
    for (int i = 0; i < N_IN; i++) stim_x[i] = 32;
    applyStimulus("after_rst", 1'b0, 1'b0, 1'b0);

    // Randomised inference/update rounds
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < NW; a++) writeWeight(a, int'($urandom_range(255)) - 128);
      for (int i = 0; i < N_IN; i++) stim_x[i] = int'($urandom_range(511)) - 256;
      applyStimulus($sformatf("rnd%0d", r), 1'($urandom_range(1)), 1'b0, 1'b0);
      for (int j = 0; j < N_OUT; j++) stim_err[j] = int'($urandom_range(255)) - 128;
      applyUpdate($sformatf("rndu%0d", r), int'($urandom_range(3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
